user_input: RTL and testbench
=============================

Name: user_input

Overview:
- Converts raw user controls into drawing-cursor state for the paint pipeline.
- Inputs: four direction buttons, a colour-cycle button and a stroke-width-cycle button, all already synchronised and debounced upstream.
- Outputs: cursor position on a 640x480 canvas, a 4-bit colour index and a 3-bit stroke width.
- Consumers: the draw/render stage.

Parameters:
- SCREEN_W, 640, canvas width in pixels; x range 0..SCREEN_W-1.
- SCREEN_H, 480, canvas height in pixels; y range 0..SCREEN_H-1.
- MOVE_PERIOD, 1_000_000, clock cycles between cursor moves while a direction is held (100 Hz at 100 MHz). Minimum value 1.
- MOVE_STEP, 1, pixels moved per tick per axis.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  reset, synchronous, active-high.
- pos_con_in  input  4  direction levels: [0]=right, [1]=left, [2]=down, [3]=up.
- col_con_in  input  1  colour-cycle button level.
- sw_con_in  input  1  stroke-width-cycle button level.
- cursor_loc_x  output  10  cursor x, registered.
- cursor_loc_y  output  9  cursor y, registered.
- cursor_color  output  4  colour index, registered.
- stroke_width  output  3  stroke width in pixels, registered, range 1..7.

Behaviour:
- Interface: single clock domain (clk_in); reset rst_in is synchronous and active-high.
- Reset values, applied at the clock edge where rst_in=1:
  - cursor_loc_x=SCREEN_W/2 (320), cursor_loc_y=SCREEN_H/2 (240).
  - cursor_color=0, stroke_width=1.
  - Tick counter=0; edge-detect history registers=0.
  - Reset overrides every other event in the same cycle.
- Edge detection:
  - col_con_in and sw_con_in each have a one-flop history register.
  - A rising edge is in=1 while prev=0.
  - A held level counts once only.
  - An input already high when reset deasserts counts as an edge on the first post-reset cycle, because history resets to 0.
- Colour: on a col_con_in rising edge, cursor_color <= cursor_color+1, mod 16 (15 wraps to 0). Visible one clock after the sampling edge.
- Stroke width: on a sw_con_in rising edge, stroke_width steps 1..7, with 7 wrapping to 1. Value 0 is never produced. Same latency as colour.
- Colour and width edges in the same cycle are independent; both update.
- Movement tick:
  - A free-running counter counts 0..MOVE_PERIOD-1 and then wraps.
  - tick=1 when the counter equals MOVE_PERIOD-1.
  - MOVE_PERIOD=1 means tick every cycle.
- On tick, per axis:
  - x: right only -> x+MOVE_STEP, saturating at SCREEN_W-1. Left only -> x-MOVE_STEP, saturating at 0. Both or neither -> hold.
  - y: down only -> y+MOVE_STEP, saturating at SCREEN_H-1. Up only -> y-MOVE_STEP, saturating at 0. Both or neither -> hold.
  - Diagonal moves (one bit per axis) update both axes on the same tick.
- Saturation arithmetic: compute in width+1 bits or compare before adding/subtracting; no wrap-around is permitted.
- Between ticks, position holds.
- Button activity never resets the tick counter.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Package user_input_pkg holds:
  - SCREEN_W/SCREEN_H defaults.
  - Direction bit index constants (DIR_RIGHT=0, DIR_LEFT=1, DIR_DOWN=2, DIR_UP=3).
  - Stroke-width bounds WIDTH_MIN=1, WIDTH_MAX=7.
- One sub-module, rising_edge_detect (clk_in, rst_in, sig_in, pulse_out), instantiated twice.
- Counter, position and cycling logic stay in user_input.

Test Plan:
- Reset: hold rst_in one cycle with all inputs 0 -> x=320, y=240, color=0, width=1 on the following cycle.
- Button cycling: 20 one-cycle pulses each of col_con_in and sw_con_in, separated by one low cycle -> color=4 (20 mod 16), width=7 (1 advanced 20 steps through 1..7). Position unchanged when pos_con_in=0.
- Held button: col_con_in high for 10 cycles -> color increments exactly once; after release and re-press, it increments again.
- Movement with MOVE_PERIOD=4, pos_con_in=4'b0001 held for 40 cycles -> x=330, y=240. With 4'b0011 (both left and right) -> x unchanged.
- Clamping with MOVE_PERIOD=1:
  - Hold up+left (4'b1010) for 500 cycles -> x=0, y=0, with no wrap.
  - Hold down+right for 700 cycles -> x=639, y=479.
- Mid-operation reset: assert rst_in while moving and after cycling -> all outputs return to reset values on the next edge. Movement resumes on the first tick after MOVE_PERIOD cycles.

Source files
------------

// File: rtl/user_input_pkg.sv
// Shared constants for the cursor/user-control block: canvas defaults,
// direction bit positions and stroke-width bounds.
package user_input_pkg;

  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  localparam logic [2:0] WIDTH_MIN = 3'd1;
  localparam logic [2:0] WIDTH_MAX = 3'd7;

endpackage

// File: rtl/rising_edge_detect.sv
// One-flop history rising-edge detector. History clears on reset, so a level
// already high when reset releases is reported as an edge on the next cycle.
module rising_edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic pulse_out
);

  logic prev_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) prev_q <= 1'b0;
    else        prev_q <= sig_in;
  end

  assign pulse_out = sig_in & ~prev_q;

endmodule

// File: rtl/user_input.sv
// Turns debounced buttons into cursor position, colour index and stroke
// width. Position moves only on movement ticks and saturates at the canvas edges.
module user_input
  import user_input_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEFAULT,
  parameter int SCREEN_H    = SCREEN_H_DEFAULT,
  parameter int MOVE_PERIOD = 1_000_000,
  parameter int MOVE_STEP   = 1
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [3:0]     pos_con_in,
  input  logic           col_con_in,
  input  logic           sw_con_in,
  output logic [X_W-1:0] cursor_loc_x,
  output logic [Y_W-1:0] cursor_loc_y,
  output logic [3:0]     cursor_color,
  output logic [2:0]     stroke_width
);

  localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [3:0]       col_q, col_d;
  logic [2:0]       wid_q, wid_d;
  logic             col_pulse, sw_pulse;
  logic             tick;
  logic [X_W:0]     x_plus;
  logic [Y_W:0]     y_plus;
  logic             go_r, go_l, go_d, go_u;

  rising_edge_detect u_col_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sig_in   (col_con_in),
    .pulse_out(col_pulse)
  );

  rising_edge_detect u_sw_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sig_in   (sw_con_in),
    .pulse_out(sw_pulse)
  );

  assign tick = (cnt_q == CNT_W'(MOVE_PERIOD - 1));

  // Opposing buttons on the same axis cancel out.
  assign go_r = pos_con_in[DIR_RIGHT] & ~pos_con_in[DIR_LEFT];
  assign go_l = pos_con_in[DIR_LEFT]  & ~pos_con_in[DIR_RIGHT];
  assign go_d = pos_con_in[DIR_DOWN]  & ~pos_con_in[DIR_UP];
  assign go_u = pos_con_in[DIR_UP]    & ~pos_con_in[DIR_DOWN];

  // One extra bit so the increment cannot wrap before the saturation compare.
  assign x_plus = {1'b0, x_q} + (X_W+1)'(MOVE_STEP);
  assign y_plus = {1'b0, y_q} + (Y_W+1)'(MOVE_STEP);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    wid_d = wid_q;

    if (tick) begin
      if (go_r) x_d = (x_plus > (X_W+1)'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : x_plus[X_W-1:0];
      if (go_l) x_d = (x_q < X_W'(MOVE_STEP)) ? '0 : x_q - X_W'(MOVE_STEP);
      if (go_d) y_d = (y_plus > (Y_W+1)'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : y_plus[Y_W-1:0];
      if (go_u) y_d = (y_q < Y_W'(MOVE_STEP)) ? '0 : y_q - Y_W'(MOVE_STEP);
    end

    if (col_pulse) col_d = col_q + 4'd1;
    if (sw_pulse)  wid_d = (wid_q == WIDTH_MAX) ? WIDTH_MIN : wid_q + 3'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      x_q   <= X_W'(SCREEN_W / 2);
      y_q   <= Y_W'(SCREEN_H / 2);
      col_q <= 4'd0;
      wid_q <= WIDTH_MIN;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      col_q <= col_d;
      wid_q <= wid_d;
    end
  end

  assign cursor_loc_x = x_q;
  assign cursor_loc_y = y_q;
  assign cursor_color = col_q;
  assign stroke_width = wid_q;

endmodule

// File: tb/tb_user_input.sv
// Bench for user_input: two instances (move period 4 and 1) share stimulus
// and are compared each cycle against an arithmetic reference model.
module tb_user_input;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] pos_in = 4'd0;
  logic       col_in = 1'b0;
  logic       sw_in = 1'b0;

  logic [9:0] x4, x1;
  logic [8:0] y4, y1;
  logic [3:0] c4, c1;
  logic [2:0] w4, w1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_input #(.MOVE_PERIOD(4)) u_p4 (
    .clk_in(clk), .rst_in(rst_in), .pos_con_in(pos_in), .col_con_in(col_in),
    .sw_con_in(sw_in), .cursor_loc_x(x4), .cursor_loc_y(y4),
    .cursor_color(c4), .stroke_width(w4)
  );

  user_input #(.MOVE_PERIOD(1)) u_p1 (
    .clk_in(clk), .rst_in(rst_in), .pos_con_in(pos_in), .col_con_in(col_in),
    .sw_con_in(sw_in), .cursor_loc_x(x1), .cursor_loc_y(y1),
    .cursor_color(c1), .stroke_width(w1)
  );

  // Reference model: index 0 = period 4, index 1 = period 1.
  int  mx[2], my[2];
  int  mcol, mwid, cyc;
  bit  pcol, psw;
  const int PERIOD[2] = '{4, 1};

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_step(input bit rst, input logic [3:0] pos, input bit col, input bit sw);
    int dx, dy;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin mx[k] = 320; my[k] = 240; end
      mcol = 0; mwid = 1; pcol = 0; psw = 0; cyc = 0;
    end else begin
      dx = int'(pos[0]) - int'(pos[1]);
      dy = int'(pos[2]) - int'(pos[3]);
      for (int k = 0; k < 2; k++) begin
        if (cyc % PERIOD[k] == PERIOD[k] - 1) begin
          mx[k] = clamp(mx[k] + dx, 0, 639);
          my[k] = clamp(my[k] + dy, 0, 479);
        end
      end
      if (col && !pcol) mcol = (mcol + 1) % 16;
      if (sw && !psw)   mwid = mwid % 7 + 1;
      pcol = col; psw = sw; cyc++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("p4_x", 32'(x4), mx[0]);   chk("p4_y", 32'(y4), my[0]);
    chk("p1_x", 32'(x1), mx[1]);   chk("p1_y", 32'(y1), my[1]);
    chk("p4_col", 32'(c4), mcol);  chk("p4_wid", 32'(w4), mwid);
    chk("p1_col", 32'(c1), mcol);  chk("p1_wid", 32'(w1), mwid);
  endtask

  task automatic cycle(input bit rst, input logic [3:0] pos, input bit col, input bit sw);
    rst_in = rst; pos_in = pos; col_in = col; sw_in = sw;
    @(posedge clk);
    model_step(rst, pos, col, sw);
    @(negedge clk);
    cmp_model();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] pos;
    bit         col;
    bit         sw;
    int         e_col;
    int         e_wid;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 4'd0, 1'b0, 1'b0, 0, 1};
    tbl[1] = '{1'b0, 4'd0, 1'b1, 1'b0, 1, 1};
    tbl[2] = '{1'b0, 4'd0, 1'b1, 1'b0, 1, 1};
    tbl[3] = '{1'b0, 4'd0, 1'b1, 1'b1, 1, 2};
    tbl[4] = '{1'b0, 4'd0, 1'b0, 1'b1, 1, 2};
    tbl[5] = '{1'b0, 4'd0, 1'b1, 1'b0, 2, 2};
    tbl[6] = '{1'b0, 4'd0, 1'b1, 1'b1, 2, 3};
    tbl[7] = '{1'b1, 4'd0, 1'b1, 1'b1, 0, 1};
    tbl[8] = '{1'b0, 4'd0, 1'b1, 1'b1, 1, 2};
    tbl[9] = '{1'b0, 4'd0, 1'b0, 1'b0, 1, 2};

    @(negedge clk);

    // Reset with all inputs low.
    cycle(1'b1, 4'd0, 1'b0, 1'b0);
    chk("rst_x", 32'(x4), 320); chk("rst_y", 32'(y4), 240);
    chk("rst_col", 32'(c4), 0); chk("rst_wid", 32'(w4), 1);
    $display("reset: x=%0d y=%0d col=%0d wid=%0d", x4, y4, c4, w4);

    // Twenty separated pulses on both cycle buttons.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 4'd0, 1'b1, 1'b1);
      cycle(1'b0, 4'd0, 1'b0, 1'b0);
    end
    chk("pulse_col", 32'(c4), 4); chk("pulse_wid", 32'(w4), 7);
    chk("pulse_x", 32'(x1), 320); chk("pulse_y", 32'(y1), 240);
    $display("pulses: col=%0d wid=%0d x=%0d y=%0d", c4, w4, x1, y1);

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].pos, tbl[i].col, tbl[i].sw);
      chk("tbl_col", 32'(c4), tbl[i].e_col);
      chk("tbl_wid", 32'(w4), tbl[i].e_wid);
      $display("vec %0d: rst=%0b col_in=%0b sw_in=%0b -> col=%0d wid=%0d", i,
               tbl[i].rst, tbl[i].col, tbl[i].sw, c4, w4);
    end

    // Held colour button counts once; re-press counts again.
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("held_col", 32'(c4), 2);
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("repress_col", 32'(c4), 3);
    $display("held: col=%0d", c4);

    // Movement right for 40 cycles, then both horizontal buttons.
    cycle(1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 4'b0001, 1'b0, 1'b0);
    chk("move_x4", 32'(x4), 330); chk("move_y4", 32'(y4), 240);
    chk("move_x1", 32'(x1), 360);
    for (int i = 0; i < 40; i++) cycle(1'b0, 4'b0011, 1'b0, 1'b0);
    chk("cancel_x4", 32'(x4), 330); chk("cancel_x1", 32'(x1), 360);
    $display("move: x4=%0d x1=%0d", x4, x1);

    // Clamp at both corners.
    cycle(1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) cycle(1'b0, 4'b1010, 1'b0, 1'b0);
    chk("clamp_lo_x", 32'(x1), 0); chk("clamp_lo_y", 32'(y1), 0);
    for (int i = 0; i < 700; i++) cycle(1'b0, 4'b0101, 1'b0, 1'b0);
    chk("clamp_hi_x", 32'(x1), 639); chk("clamp_hi_y", 32'(y1), 479);
    $display("clamp: x1=%0d y1=%0d", x1, y1);

    // Reset mid-motion, then movement resumes after a full period.
    cycle(1'b0, 4'b0101, 1'b1, 1'b1);
    cycle(1'b1, 4'b0101, 1'b0, 1'b0);
    chk("mid_rst_x", 32'(x4), 320); chk("mid_rst_col", 32'(c4), 0);
    chk("mid_rst_wid", 32'(w4), 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0001, 1'b0, 1'b0);
    chk("resume_wait_x4", 32'(x4), 320);
    cycle(1'b0, 4'b0001, 1'b0, 1'b0);
    chk("resume_x4", 32'(x4), 321);
    $display("mid reset: x4=%0d", x4);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      automatic bit         r = ($urandom_range(0, 63) == 0);
      automatic logic [3:0] p = 4'($urandom_range(0, 15));
      automatic bit         c = 1'($urandom_range(0, 1));
      automatic bit         s = 1'($urandom_range(0, 1));
      cycle(r, p, c, s);
      $display("rand %0d: rst=%0b pos=%b col_in=%0b sw_in=%0b -> x4=%0d y4=%0d x1=%0d y1=%0d col=%0d wid=%0d",
               i, r, p, c, s, x4, y4, x1, y1, c4, w4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
